// File: rtl/riscv_if_if.sv
// Instruction-memory read bus: the fetch stage is the master, instruction memory the slave.
interface riscv_if_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/riscv_if.sv
// Instruction fetch stage: one outstanding word read, a 2-entry instruction buffer
// feeding decode over valid/ready, redirect flush and fetch-fault reporting.
module riscv_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  riscv_if_if.master        mem,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       instruction,
  output logic [31:0]       pc,
  output logic              exception
);

  typedef enum logic [1:0] {REQ, WAIT, HALT, DROP} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } entry_t;

  localparam entry_t EMPTY = '{instr: NOP, pc: 32'h0, exc: 1'b0};

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        id_valid_q, id_valid_d;

  logic        push;
  logic        pop;
  entry_t      push_entry;
  logic        in_flight;

  // A request is owed a response if it was granted this cycle or is still waiting.
  assign in_flight = (state_q == DROP)
                   || (state_q == WAIT && !mem.mem_rvalid)
                   || (state_q == REQ && mem_req_q && mem.mem_gnt);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    push_entry = EMPTY;
    pop        = id_valid_q & id_ready;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    case (state_q)
      REQ: begin
        if (fetch_pc_q[1:0] != 2'b00) begin
          // Misaligned target: report it as a buffered fault instead of fetching.
          if (count_q != 2'd2) begin
            push       = 1'b1;
            push_entry = '{instr: NOP, pc: fetch_pc_q, exc: 1'b1};
            state_d    = HALT;
          end
        end else if (mem_req_q && mem.mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          push       = 1'b1;
          push_entry = '{instr: mem.mem_rdata, pc: fetch_pc_q, exc: mem.mem_err};
          if (mem.mem_err) begin
            state_d = HALT;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = REQ;
          end
        end
      end
      DROP: begin
        if (mem.mem_rvalid) state_d = REQ;
      end
      default: ;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = 2'd0;
      head_d     = EMPTY;
      state_d    = in_flight ? DROP : REQ;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_entry;
          else                 tail_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = (count_q == 2'd2) ? tail_q : EMPTY;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_entry;
          end else begin
            head_d = push_entry;
          end
        end
        default: ;
      endcase
    end

    // Bus outputs are registered, so they are computed from the next-cycle view.
    mem_req_d  = (state_d == REQ) && (count_d != 2'd2) && (fetch_pc_d[1:0] == 2'b00);
    mem_addr_d = fetch_pc_d;
    id_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= EMPTY;
      tail_q     <= EMPTY;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      id_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign id_valid     = id_valid_q;
  assign instruction  = head_q.instr;
  assign pc           = head_q.pc;
  assign exception    = head_q.exc;

endmodule

// File: tb/tb_riscv_if.sv
// Directed bench for riscv_if: a one-cycle-latency memory model answers requests with
// rdata = addr ^ 32'hA5A5_0000 while a linear sequence exercises fetch, stalls and redirects.
module tb_riscv_if;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        exception;

  riscv_if_if mem_bus ();

  riscv_if dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mem_bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .instruction (instruction),
    .pc          (pc),
    .exception   (exception)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Memory model controls
  logic        gnt_en   = 1'b0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  // Memory model: grants whenever enabled, answers on the following cycle.
  initial begin : mem_model
    logic        pend;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_addr = 32'h0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    mem_bus.mem_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        mem_bus.mem_err    = 1'b0;
      end else begin
        mem_bus.mem_rvalid = pend;
        mem_bus.mem_rdata  = pend ? (pend_addr ^ XOR_KEY) : 32'hDEAD_BEEF;
        mem_bus.mem_err    = pend && err_en && (pend_addr == err_addr);
        mem_bus.mem_gnt    = gnt_en && mem_bus.mem_req;
        pend      = gnt_en && mem_bus.mem_req;
        pend_addr = mem_bus.mem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    gnt_en = 1'b1;
    err_en = 1'b0;
    repeat (3) step();
  endtask

  // Waits (bounded) for a head entry, checks it, then lets it pop (id_ready must be 1).
  task automatic wait_pop(input logic [31:0] epc, input logic [31:0] einstr,
                          input logic eexc, input string tag, output int t);
    int n = 0;
    while (!id_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, id_valid, 1);
    check({tag, "_pc"}, pc, epc);
    check({tag, "_instr"}, instruction, einstr);
    check({tag, "_exc"}, exception, eexc);
    t = cyc;
    step();
  endtask

  // Waits (bounded) for a request at the given address.
  task automatic wait_req(input logic [31:0] addr, input string tag);
    int n = 0;
    while (!(mem_bus.mem_req && mem_bus.mem_addr == addr) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_req"}, mem_bus.mem_req, 1);
    check({tag, "_addr"}, mem_bus.mem_addr, addr);
  endtask

  initial begin : stimulus
    int t0, t1, t2, t3;
    int req_seen;

    // Reset values and sequential fetch
    id_ready = 1'b1;
    hold_reset();
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_id_valid", id_valid, 0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 32'h0);
    check("rst_exc", exception, 0);
    rst = 1'b1;
    wait_pop(32'h0, 32'hA5A5_0000, 1'b0, "seq0", t0);
    wait_pop(32'h4, 32'hA5A5_0004, 1'b0, "seq4", t1);
    wait_pop(32'h8, 32'hA5A5_0008, 1'b0, "seq8", t2);
    wait_pop(32'hC, 32'hA5A5_000C, 1'b0, "seq12", t3);
    check("seq_gap1", t1 - t0, 2);
    check("seq_gap2", t2 - t1, 2);
    check("seq_gap3", t3 - t2, 2);

    // Backpressure: buffer fills with two entries and requests stop
    id_ready = 1'b0;
    hold_reset();
    rst = 1'b1;
    repeat (10) step();
    check("bp_valid", id_valid, 1);
    check("bp_head_pc", pc, 32'h0);
    check("bp_req_off", mem_bus.mem_req, 0);
    check("bp_next_addr", mem_bus.mem_addr, 32'h8);
    id_ready = 1'b1;
    step();
    check("bp_head4_valid", id_valid, 1);
    check("bp_head4_pc", pc, 32'h4);
    check("bp_head4_instr", instruction, 32'hA5A5_0004);
    check("bp_resume_req", mem_bus.mem_req, 1);
    step();
    wait_pop(32'h8, 32'hA5A5_0008, 1'b0, "bp8", t0);
    wait_pop(32'hC, 32'hA5A5_000C, 1'b0, "bp12", t1);

    // Redirect coinciding with the grant for pc 8
    hold_reset();
    rst = 1'b1;
    wait_req(32'h8, "rd_pre");
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("rd_drop_req", mem_bus.mem_req, 0);
    check("rd_flush_valid", id_valid, 0);
    step();
    check("rd_new_req", mem_bus.mem_req, 1);
    check("rd_new_addr", mem_bus.mem_addr, 32'h100);
    wait_pop(32'h100, 32'hA5A5_0100, 1'b0, "rd100", t0);
    wait_pop(32'h104, 32'hA5A5_0104, 1'b0, "rd104", t0);

    // Misaligned redirect target
    id_ready = 1'b0;
    hold_reset();
    gnt_en = 1'b0;
    rst = 1'b1;
    wait_req(32'h0, "mis_pre");
    redirect = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    gnt_en = 1'b1;
    check("mis_no_req", mem_bus.mem_req, 0);
    step();
    check("mis_valid", id_valid, 1);
    check("mis_pc", pc, 32'h102);
    check("mis_instr", instruction, NOP);
    check("mis_exc", exception, 1);
    id_ready = 1'b1;
    step();
    check("mis_popped", id_valid, 0);
    req_seen = 0;
    repeat (8) begin
      if (mem_bus.mem_req) req_seen++;
      step();
    end
    check("mis_idle_req", req_seen, 0);
    check("mis_idle_valid", id_valid, 0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("mis_resume_req", mem_bus.mem_req, 1);
    check("mis_resume_addr", mem_bus.mem_addr, 32'h200);
    wait_pop(32'h200, 32'hA5A5_0200, 1'b0, "mis200", t0);

    // Memory error on pc 4
    hold_reset();
    err_en = 1'b1;
    err_addr = 32'h4;
    rst = 1'b1;
    wait_pop(32'h0, 32'hA5A5_0000, 1'b0, "err0", t0);
    wait_pop(32'h4, 32'hA5A5_0004, 1'b1, "err4", t0);
    req_seen = 0;
    repeat (8) begin
      if (mem_bus.mem_req) req_seen++;
      step();
    end
    check("err_idle_req", req_seen, 0);
    check("err_idle_valid", id_valid, 0);
    err_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    wait_pop(32'h40, 32'hA5A5_0040, 1'b0, "err40", t0);

    // Reset asserted while a response is outstanding and an entry is buffered
    id_ready = 1'b0;
    hold_reset();
    rst = 1'b1;
    wait_req(32'h4, "mrst_pre");
    step();
    check("mrst_wait_req", mem_bus.mem_req, 0);
    check("mrst_wait_valid", id_valid, 1);
    rst = 1'b0;
    #1;
    check("mrst_valid", id_valid, 0);
    check("mrst_req", mem_bus.mem_req, 0);
    check("mrst_pc", pc, 32'h0);
    check("mrst_instr", instruction, NOP);
    check("mrst_addr", mem_bus.mem_addr, 32'h0);
    repeat (2) step();
    rst = 1'b1;
    id_ready = 1'b1;
    wait_req(32'h0, "mrst_first");
    wait_pop(32'h0, 32'hA5A5_0000, 1'b0, "mrst0", t0);
    wait_pop(32'h4, 32'hA5A5_0004, 1'b0, "mrst4", t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
